// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data (load/store) requester.
//   clk, rst                   clock, async active-high reset
//   if_req/if_addr/if_flush    fetch request, address, flush (cancel)
//   if_rdata/if_ready          fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, store data
//   d_rdata/d_ready            load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory access (held until mem_ack)
//   mem_rdata/mem_ack          memory read data and completion
// Data wins ties unless the fetch has waited STARVE_MAX data grants (1..15).
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic             r_mem_en,     w_mem_en_nxt;
  logic             r_mem_we,     w_mem_we_nxt;
  logic [AW-1:0]    r_mem_addr,   w_mem_addr_nxt;
  logic [DW-1:0]    r_mem_wdata,  w_mem_wdata_nxt;
  logic             r_if_ready,   w_if_ready_nxt;
  logic             r_d_ready,    w_d_ready_nxt;
  logic [DW-1:0]    r_if_rdata,   w_if_rdata_nxt;
  logic [DW-1:0]    r_d_rdata,    w_d_rdata_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;
  logic             r_flush,      w_flush_nxt;

  logic w_if_ok;
  logic w_starved;

  // A fetch that coincides with a flush is never granted.
  assign w_if_ok   = if_req & ~if_flush;
  assign w_starved = (r_starve_cnt == STARVE_LIM);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_en_nxt     = r_mem_en;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_if_ready_nxt   = 1'b0;
    w_d_ready_nxt    = 1'b0;
    w_if_rdata_nxt   = r_if_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_starve_cnt_nxt = r_starve_cnt;
    w_flush_nxt      = r_flush;

    case (r_state)
      IDLE: begin
        if (d_req && (!w_if_ok || !w_starved)) begin
          w_state_nxt     = BUSY_D;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = d_we;
          w_mem_addr_nxt  = d_addr;
          w_mem_wdata_nxt = d_wdata;
          // Only data grants that bypass a waiting fetch count as starvation.
          if (if_req && !w_starved) begin
            w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
          end
        end else if (w_if_ok) begin
          w_state_nxt      = BUSY_I;
          w_mem_en_nxt     = 1'b1;
          w_mem_we_nxt     = 1'b0;
          w_mem_addr_nxt   = if_addr;
          w_starve_cnt_nxt = '0;
          w_flush_nxt      = 1'b0;
        end
      end
      BUSY_I: begin
        if (if_flush) begin
          w_flush_nxt = 1'b1;
        end
        if (mem_ack) begin
          w_state_nxt  = DONE;
          w_mem_en_nxt = 1'b0;
          w_mem_we_nxt = 1'b0;
          w_flush_nxt  = 1'b0;
          // A flushed fetch still completes on memory but is hidden from the core.
          if (!(r_flush || if_flush)) begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          w_state_nxt   = DONE;
          w_mem_en_nxt  = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_d_ready_nxt = 1'b1;
          w_d_rdata_nxt = mem_rdata;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_ready   <= 1'b0;
      r_d_ready    <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_starve_cnt <= '0;
      r_flush      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_if_ready   <= w_if_ready_nxt;
      r_d_ready    <= w_d_ready_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_flush      <= w_flush_nxt;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// request bursts checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic          if_ready, d_ready, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            model_starve = 0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata  = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle mem_en rises; acks lat cycles later, returns in the ready cycle.
  task automatic ack_after(input int lat, input logic [DW-1:0] data);
    repeat (lat) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    rst = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    repeat (3) tick();
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata} !== '0) begin n_fail++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0 (mem_en=%b addr=%h)", mem_en, mem_addr); end
    rst = 1'b0;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_no_early_grant: got mem_en=%b, expected 0", mem_en); end
    tick();
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant: got mem_en=%b, expected 1", mem_en); end
    n_checks++; if (mem_addr !== 32'h44) begin n_fail++; $display("FAIL reset_first_addr: got %h, expected 44", mem_addr); end
    rd = $urandom;
    ack_after(1, rd);
    n_checks++; if (d_ready !== 1'b1 || d_rdata !== rd) begin n_fail++; $display("FAIL reset_first_load: got ready=%b data=%h, expected 1/%h", d_ready, d_rdata, rd); end
    exp_d_rdata = rd;
    d_req = 1'b0;
    tick();
    n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pulse: got d_ready=%b, expected 0", d_ready); end
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    model_starve = 0;
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_grant: got en=%b addr=%h we=%b, expected 1/40/0", mem_en, mem_addr, mem_we); end
    ack_after(2, 32'h00A00093);
    n_checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h00A00093) begin n_fail++; $display("FAIL fetch_ready: got ready=%b data=%h, expected 1/00a00093", if_ready, if_rdata); end
    n_checks++; if (mem_en !== 1'b0 || d_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_done_state: got en=%b d_ready=%b, expected 0/0", mem_en, d_ready); end
    exp_if_rdata = 32'h00A00093;
    if_req = 1'b0;
    tick();
    n_checks++; if (if_ready !== 1'b0 || if_rdata !== exp_if_rdata) begin n_fail++; $display("FAIL fetch_pulse_hold: got ready=%b data=%h, expected 0/%h", if_ready, if_rdata, exp_if_rdata); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] rd;
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_fail++; $display("FAIL simul_data_first: got en=%b addr=%h we=%b, expected 1/10/0", mem_en, mem_addr, mem_we); end
    model_starve = (model_starve < SMAX) ? model_starve + 1 : model_starve;
    rd = $urandom;
    ack_after(1, rd);
    n_checks++; if (d_ready !== 1'b1 || d_rdata !== rd || if_ready !== 1'b0) begin n_fail++; $display("FAIL simul_d_ready: got d=%b data=%h i=%b, expected 1/%h/0", d_ready, d_rdata, if_ready, rd); end
    exp_d_rdata = rd;
    d_req = 1'b0;
    tick();
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL simul_idle_gap: got mem_en=%b, expected 0", mem_en); end
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL simul_fetch_grant: got en=%b addr=%h, expected 1/80", mem_en, mem_addr); end
    model_starve = 0;
    rd = $urandom;
    ack_after(1, rd);
    n_checks++; if (if_ready !== 1'b1 || if_rdata !== rd) begin n_fail++; $display("FAIL simul_if_ready: got ready=%b data=%h, expected 1/%h", if_ready, if_rdata, rd); end
    exp_if_rdata = rd;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [DW-1:0] rd;
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int k = 0; k < SMAX; k++) begin
      tick();
      n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h300 + 32'(4 * k)) begin n_fail++; $display("FAIL starve_data_grant%0d: got en=%b addr=%h, expected 1/%h", k, mem_en, mem_addr, 32'h300 + 32'(4 * k)); end
      model_starve = (model_starve < SMAX) ? model_starve + 1 : model_starve;
      n_checks++; if (dut.r_starve_cnt !== 4'(model_starve)) begin n_fail++; $display("FAIL starve_count%0d: got %0d, expected %0d", k, dut.r_starve_cnt, model_starve); end
      rd = $urandom;
      ack_after(1, rd);
      n_checks++; if (d_ready !== 1'b1 || d_rdata !== rd || if_ready !== 1'b0) begin n_fail++; $display("FAIL starve_d_ready%0d: got d=%b data=%h i=%b, expected 1/%h/0", k, d_ready, d_rdata, if_ready, rd); end
      exp_d_rdata = rd;
      d_addr = 32'h300 + 32'(4 * (k + 1));
      tick();
    end
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin n_fail++; $display("FAIL starve_fetch_grant: got en=%b addr=%h we=%b, expected 1/200/0", mem_en, mem_addr, mem_we); end
    model_starve = 0;
    n_checks++; if (dut.r_starve_cnt !== 4'(model_starve)) begin n_fail++; $display("FAIL starve_cleared: got %0d, expected 0", dut.r_starve_cnt); end
    rd = $urandom;
    ack_after(2, rd);
    n_checks++; if (if_ready !== 1'b1 || if_rdata !== rd) begin n_fail++; $display("FAIL starve_if_ready: got ready=%b data=%h, expected 1/%h", if_ready, if_rdata, rd); end
    exp_if_rdata = rd;
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [DW-1:0] rd;
    if_req = 1'b1; if_addr = 32'h400; if_flush = 1'b1;
    tick();
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL flush_idle_nogrant: got mem_en=%b, expected 0", mem_en); end
    if_flush = 1'b0;
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h400) begin n_fail++; $display("FAIL flush_grant: got en=%b addr=%h, expected 1/400", mem_en, mem_addr); end
    model_starve = 0;
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_req = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL flush_mem_completes: got mem_en=%b, expected 1", mem_en); end
    tick();
    mem_ack = 1'b0;
    n_checks++; if (mem_en !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_suppress: got en=%b ready=%b, expected 0/0", mem_en, if_ready); end
    n_checks++; if (if_rdata !== exp_if_rdata) begin n_fail++; $display("FAIL flush_rdata_kept: got %h, expected %h", if_rdata, exp_if_rdata); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    tick();
    n_checks++; if (mem_en !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_done_no_grant: got en=%b ready=%b, expected 0/0", mem_en, if_ready); end
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL flush_next_grant: got en=%b addr=%h, expected 1/500", mem_en, mem_addr); end
    rd = $urandom;
    ack_after(1, rd);
    n_checks++; if (d_ready !== 1'b1 || d_rdata !== rd) begin n_fail++; $display("FAIL flush_after_load: got ready=%b data=%h, expected 1/%h", d_ready, d_rdata, rd); end
    exp_d_rdata = rd;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    logic [DW-1:0] rd;
    int            ready_seen;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    rd = $urandom;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL store_hold_c%0d: got en=%b we=%b addr=%h wdata=%h, expected 1/1/20/12345678", c, mem_en, mem_we, mem_addr, mem_wdata); end
      if (c == 4) begin mem_ack = 1'b1; mem_rdata = rd; end
    end
    tick();
    mem_ack = 1'b0;
    n_checks++; if (d_ready !== 1'b1 || mem_en !== 1'b0 || d_rdata !== rd) begin n_fail++; $display("FAIL store_ready: got ready=%b en=%b data=%h, expected 1/0/%h", d_ready, mem_en, d_rdata, rd); end
    exp_d_rdata = rd;
    d_req = 1'b0; d_we = 1'b0;
    ready_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (d_ready === 1'b1) ready_seen++;
    end
    n_checks++; if (ready_seen !== 0) begin n_fail++; $display("FAIL store_single_pulse: got %0d extra pulses, expected 0", ready_seen); end
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'hCAFE0000;
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got en=%b we=%b, expected 1/1", mem_en, mem_we); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata} !== '0) begin n_fail++; $display("FAIL midrst_async_clear: got en=%b addr=%h if_rdata=%h, expected all 0", mem_en, mem_addr, if_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    rst = 1'b0;
    model_starve = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0;
    n_checks++; if (d_ready !== 1'b0 || mem_en !== 1'b0 || d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL midrst_ack_ignored: got ready=%b en=%b data=%h, expected 0/0/0", d_ready, mem_en, d_rdata); end
    tick();
    n_checks++; if (d_ready !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_no_ready: got d=%b i=%b, expected 0/0", d_ready, if_ready); end
  endtask

  // Random bursts: a fetch and/or a run of back-to-back data requests.
  task automatic test_random();
    int            if_pend, d_cnt, lat, data_win;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] rd;
    for (int r = 0; r < 14; r++) begin
      if_pend = int'($urandom_range(0, 1));
      d_cnt   = int'($urandom_range(0, 6));
      if (if_pend == 0 && d_cnt == 0) d_cnt = 1;
      if_req  = (if_pend != 0);
      if_addr = $urandom & 32'hFFFF_FFFC;
      d_req   = (d_cnt > 0);
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      tick();
      while (if_pend != 0 || d_cnt > 0) begin
        data_win = (d_cnt > 0 && (if_pend == 0 || model_starve != SMAX)) ? 1 : 0;
        e_addr   = (data_win != 0) ? d_addr : if_addr;
        if (data_win != 0) begin
          if (if_pend != 0 && model_starve < SMAX) model_starve++;
        end else begin
          model_starve = 0;
        end
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd%0d_grant: got en=%b addr=%h, expected 1/%h", r, mem_en, mem_addr, e_addr); end
        n_checks++; if (mem_we !== ((data_win != 0) ? d_we : 1'b0) || (data_win != 0 && d_we && mem_wdata !== d_wdata)) begin n_fail++; $display("FAIL rnd%0d_write: got we=%b wdata=%h, expected we=%b wdata=%h", r, mem_we, mem_wdata, (data_win != 0) ? d_we : 1'b0, d_wdata); end
        lat = int'($urandom_range(1, 4));
        rd  = $urandom;
        ack_after(lat, rd);
        if (data_win != 0) begin
          n_checks++; if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== rd) begin n_fail++; $display("FAIL rnd%0d_d_done: got d=%b i=%b data=%h, expected 1/0/%h", r, d_ready, if_ready, d_rdata, rd); end
          exp_d_rdata = rd;
          d_cnt--;
          d_req   = (d_cnt > 0);
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom & 32'hFFFF_FFFC;
          d_wdata = $urandom;
        end else begin
          n_checks++; if (if_ready !== 1'b1 || d_ready !== 1'b0 || if_rdata !== rd) begin n_fail++; $display("FAIL rnd%0d_i_done: got i=%b d=%b data=%h, expected 1/0/%h", r, if_ready, d_ready, if_rdata, rd); end
          exp_if_rdata = rd;
          if_pend = 0;
          if_req  = 1'b0;
        end
        tick();
        n_checks++; if (mem_en !== 1'b0 || if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL rnd%0d_idle: got en=%b if_rdata=%h d_rdata=%h, expected 0/%h/%h", r, mem_en, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata); end
        if (if_pend != 0 || d_cnt > 0) tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
    mem_ack = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 32, address width of both requesters and the memory port.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter STARVE_MAX, 4, maximum consecutive data grants while a fetch waits; legal range 1..15.
REQ-004 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port if_req  in  1  fetch request; held until if_ready or if_flush.
REQ-007 Port if_addr  in  AW  fetch address; stable while if_req is high.
REQ-008 Port if_flush  in  1  branch flush; cancels the outstanding fetch.
REQ-009 Port if_rdata  out  DW  fetched word; valid while if_ready is high.
REQ-010 Port if_ready  out  1  one-cycle fetch-complete pulse.
REQ-011 Port d_req  in  1  data request; held until d_ready.
REQ-012 Port d_we  in  1  data write enable (1 = store).
REQ-013 Port d_addr  in  AW  data address.
REQ-014 Port d_wdata  in  DW  store data.
REQ-015 Port d_rdata  out  DW  load data; valid while d_ready is high.
REQ-016 Port d_ready  out  1  one-cycle data-complete pulse.
REQ-017 Port mem_en  out  1  memory access active.
REQ-018 Port mem_we  out  1  memory write.
REQ-019 Port mem_addr  out  AW  memory address.
REQ-020 Port mem_wdata  out  DW  memory write data.
REQ-021 Port mem_rdata  in  DW  memory read data; valid when mem_ack is high.
REQ-022 Port mem_ack  in  1  memory completion; arrives 1 or more cycles after mem_en rises.

Function
REQ-023 The FSM SHALL have the states IDLE, BUSY_I, BUSY_D and DONE, all registered.
REQ-024 IDLE SHALL take the following transitions at the edge:
- d_req only -> BUSY_D.
- if_req only (and if_flush low) -> BUSY_I.
- both requests -> BUSY_D, unless starve_cnt == STARVE_MAX, in which case -> BUSY_I.
REQ-025 In IDLE, an if_req that coincides with if_flush SHALL NOT be granted.
REQ-026 In BUSY_I and BUSY_D, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL be latched at grant and held until mem_ack.
- BUSY_I latches if_addr, mem_we = 0.
- BUSY_D latches d_addr, d_we and d_wdata.
REQ-027 A mem_ack in a BUSY state SHALL capture mem_rdata into the granted requester's rdata register and move the FSM to DONE.
REQ-028 DONE SHALL last exactly one cycle, with mem_en = 0, the granted requester's ready = 1 and no new grant, and SHALL then return to IDLE.
REQ-029 Latency from the request edge to ready SHALL be L + 2 cycles, where L is the number of cycles from mem_en rising to mem_ack (minimum 1 cycle after grant).
REQ-030 A fetch flushed while in BUSY_I SHALL still complete on the memory side, but the arbiter SHALL suppress if_ready in DONE and leave if_rdata unchanged.
- Flush is sticky until DONE.
- Data accesses cannot be cancelled.
REQ-031 starve_cnt SHALL be a 4-bit counter handled as follows:
- It SHALL increment on each data grant made while if_req is high.
- It SHALL saturate at STARVE_MAX.
- It SHALL clear on any fetch grant.
- It SHALL be left unchanged when if_req is low.
REQ-032 In IDLE and DONE, mem_ack SHALL be ignored.
REQ-033 if_rdata and d_rdata SHALL hold their values between completions.
REQ-034 Outputs SHALL be glitch-free functions of registered state only, with no combinational path from any input to any output.

Reset
REQ-035 While rst is high, the block SHALL immediately (asynchronously) force state = IDLE, mem_en = mem_we = 0, mem_addr = mem_wdata = 0, if_ready = d_ready = 0, if_rdata = d_rdata = 0, starve_cnt = 0 and flush flag = 0.
REQ-036 A reset asserted during BUSY_* SHALL abandon the access; a mem_ack arriving after reset release SHALL be ignored.
REQ-037 The first grant after reset release SHALL occur no earlier than the first rising edge at which rst is low.

Verification
REQ-038 The bench SHALL check a single fetch: if_req, if_addr = 0x40, mem_ack 2 cycles after mem_en with mem_rdata = 0x00A00093 -> mem_addr = 0x40, mem_we = 0, if_ready pulses for 1 cycle 4 cycles after the request with if_rdata = 0x00A00093.
REQ-039 The bench SHALL check a simultaneous request: if_req and d_req (load, d_addr = 0x10) together -> data served first and d_ready pulses, then fetch granted from IDLE, and if_ready pulses.
REQ-040 The bench SHALL check starvation: if_req held high, d_req re-asserted back-to-back, STARVE_MAX = 4 -> exactly 4 data grants, then a fetch grant, then starve_cnt = 0.
REQ-041 The bench SHALL check a flush: if_flush pulsed during BUSY_I, mem_ack later with 0xDEADBEEF -> mem_en drops at ack, if_ready stays 0, if_rdata keeps its old value, and the FSM reaches IDLE via DONE.
REQ-042 The bench SHALL check a store: d_we = 1, d_addr = 0x20, d_wdata = 0x12345678 -> mem_we = 1 and mem_wdata = 0x12345678 until mem_ack, then d_ready pulses once.
REQ-043 The bench SHALL check reset mid-access: rst pulsed in BUSY_D, then mem_ack after release -> all outputs 0 during reset, the ack is ignored and no ready pulse occurs.
